gcbp_search_sched: RTL
======================

# gcbp_search_sched

Sequencing controller for the GCBP BRAM array. Owns the three-slot frame-buffer rotation (next/curr/prev locations) and, after each completed frame, walks all 16 sub-images, issuing BRAM read commands for the current and previous frames to the GCBP matcher.

## Interface
Parameters:
- C_SUBIMAGE_HEIGHT, 64: lines per sub-image, and rows read per sub-image per frame.
- C_NUM_SUBIMAGES, 16: sub-images per frame, one per BRAM (4 rows x 4 columns).
- C_ADDR_BITS, 9: BRAM read address width.
- C_FRAME_BASE_SHIFT, 7: a frame slot's base address is loc << C_FRAME_BASE_SHIFT.

Ports:
- i_clk  in  1  single clock; all state is on its rising edge.
- i_resetn  in  1  asynchronous, active-low reset.
- i_frame_done  in  1  one-cycle pulse from the write side: the frame at o_next_frame_loc is complete.
- i_cmd_ready  in  1  matcher accepts the presented command.
- i_match_done  in  1  one-cycle pulse: matcher has finished the current sub-image.
- o_next_frame_loc  out  2  slot being written.
- o_curr_frame_loc  out  2  slot holding the newest complete frame.
- o_prev_frame_loc  out  2  slot holding the frame before that.
- o_cmd_valid  out  1  read command valid.
- o_rd_addr  out  C_ADDR_BITS  BRAM read address.
- o_rd_sel  out  4  BRAM/sub-image index 0..15.
- o_rd_curr  out  1  1 = command reads the curr frame, 0 = the prev frame.
- o_busy  out  1  high whenever the state is not S_IDLE.
- o_search_done  out  1  one-cycle pulse after sub-image 15 completes.
- o_overrun  out  1  one-cycle pulse when a frame_done is dropped.

## Operation
- Reset values: next=0, curr=1, prev=2; all other outputs 0; state S_IDLE; pending=0; frames_seen=0.
- All outputs are registered.
- Rotation (on entry to S_ROTATE): prev<=curr, curr<=next, next<=old prev. The three locations always remain a permutation of {0,1,2}.
- frames_seen is a 2-bit counter that saturates at 2 and increments on every rotation.
- FSM states and transitions:
  - S_IDLE: on i_frame_done or pending=1, go to S_ROTATE and clear pending.
  - S_ROTATE: one cycle; rotate locations. Go to S_ISSUE if the search is enabled (see Configuration), otherwise to S_IDLE.
  - S_ISSUE: present commands. Each row r (0..63) of sub-image s produces two commands: curr first, then prev. Address = (loc << C_FRAME_BASE_SHIFT) + r.
  - S_ISSUE -> S_WAIT_MATCH after the handshake of the last command of the sub-image (r=63, prev).
  - S_WAIT_MATCH: on i_match_done, go to S_ISSUE with s+1. When s=15, go to S_DONE instead.
  - S_DONE: one cycle with o_search_done=1; row and sub-image counters reset to 0; go to S_IDLE.
- Handshake: a command is transferred on any cycle with o_cmd_valid && i_cmd_ready. While o_cmd_valid is high and i_cmd_ready is low, o_rd_addr, o_rd_sel and o_rd_curr hold stable. o_cmd_valid never drops without a transfer, except on reset.
- i_match_done received outside S_WAIT_MATCH is ignored.
- A frame_done arriving while busy sets pending; rotation is deferred until S_IDLE is reached.
- A frame_done arriving while pending is already set pulses o_overrun; pending stays 1.
- Simultaneous i_frame_done and S_DONE exit: the frame_done is captured as pending and serviced from S_IDLE on the next cycle.
- Asserting reset mid-search immediately returns every register to its reset value. The partially issued search is discarded.

## Timing
- i_frame_done sampled at edge E (in S_IDLE) -> S_ROTATE during cycle E..E+1.
- New locations are visible after edge E+1.
- First o_cmd_valid=1 after edge E+2.
- Throughput with i_cmd_ready tied high: one command per cycle, so 128 cycles per sub-image plus the matcher wait.
- o_search_done asserts one cycle after the i_match_done for s=15.
- Address arithmetic: the base fits in C_ADDR_BITS; r < 2^C_FRAME_BASE_SHIFT, so there is no carry into the slot bits.

## Configuration
- GCBP_SEARCH_WARMUP_EN defined: S_ROTATE goes to S_ISSUE only when frames_seen (after increment) equals 2. The first frame after reset rotates locations without starting a search.
- GCBP_SEARCH_WARMUP_EN undefined: every rotation starts a search, including the first frame after reset.

## Test plan
- Reset, then pulse i_frame_done once with the macro defined -> after rotation next=2, curr=0, prev=1; o_cmd_valid stays 0; o_busy returns to 0 after 2 cycles.
- Second i_frame_done, i_cmd_ready=1 -> locations next=1, curr=2, prev=0. First command is addr 256, sel 0, curr=1; second is addr 0, sel 0, curr=0. 128 commands, then the block waits for i_match_done.
- Toggle i_cmd_ready randomly during S_ISSUE -> o_rd_addr, o_rd_sel and o_rd_curr are stable while stalled; exactly 128 transfers per sub-image, with none lost or duplicated.
- Answer i_match_done for all 16 sub-images -> the last command is sel 15, addr (prev<<7)+63. o_search_done pulses once, then o_busy=0.
- During a search, pulse i_frame_done twice -> pending is set on the first pulse and o_overrun pulses on the second. After S_DONE, the block re-enters S_ROTATE and starts a new search.
- Deassert i_resetn mid-search (asynchronous, between edges) -> outputs return immediately to reset values: locations 0/1/2, o_cmd_valid=0.

Source files
------------

// File: rtl/gcbp_search_sched_if.sv
// Command/status bundle between gcbp_search_sched (master) and the write side / GCBP matcher (slave).
// Command channel: a read command transfers on any rising edge where o_cmd_valid && i_cmd_ready; while
// valid is high and ready low, addr/sel/curr hold stable and valid only drops after a transfer.
interface gcbp_search_sched_if #(
  parameter int C_ADDR_BITS = 9
) ();
  logic                   i_frame_done;
  logic                   i_cmd_ready;
  logic                   i_match_done;
  logic [1:0]             o_next_frame_loc;
  logic [1:0]             o_curr_frame_loc;
  logic [1:0]             o_prev_frame_loc;
  logic                   o_cmd_valid;
  logic [C_ADDR_BITS-1:0] o_rd_addr;
  logic [3:0]             o_rd_sel;
  logic                   o_rd_curr;
  logic                   o_busy;
  logic                   o_search_done;
  logic                   o_overrun;
  logic [2:0]             state_dbg;

  modport master (
    input  i_frame_done, i_cmd_ready, i_match_done,
    output o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc,
    output o_cmd_valid, o_rd_addr, o_rd_sel, o_rd_curr,
    output o_busy, o_search_done, o_overrun, state_dbg
  );

  modport slave (
    output i_frame_done, i_cmd_ready, i_match_done,
    input  o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc,
    input  o_cmd_valid, o_rd_addr, o_rd_sel, o_rd_curr,
    input  o_busy, o_search_done, o_overrun, state_dbg
  );
endinterface

// File: rtl/gcbp_search_sched.sv
// GCBP frame-slot rotation and per-sub-image read-command sequencer; all outputs registered.
// Optional macro GCBP_SEARCH_WARMUP_EN: skip the search until two frames have been rotated in.
module gcbp_search_sched #(
  parameter int C_SUBIMAGE_HEIGHT  = 64,
  parameter int C_NUM_SUBIMAGES    = 16,
  parameter int C_ADDR_BITS        = 9,
  parameter int C_FRAME_BASE_SHIFT = 7
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  gcbp_search_sched_if.master  bus
);

  localparam int ROW_BITS = $clog2(C_SUBIMAGE_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROTATE     = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_MATCH = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                 state, state_d;
  logic [1:0]             next_loc, next_loc_d, curr_loc, curr_loc_d, prev_loc, prev_loc_d;
  logic                   pending, pending_d;
  logic [1:0]             seen, seen_d;
  logic [ROW_BITS-1:0]    row, row_d, nrow;
  logic [3:0]             sub, sub_d;
  logic                   phase, phase_d, nphase;
  logic                   cmd_valid, cmd_valid_d;
  logic [C_ADDR_BITS-1:0] rd_addr, rd_addr_d;
  logic [3:0]             rd_sel, rd_sel_d;
  logic                   rd_curr, rd_curr_d;
  logic                   busy, busy_d;
  logic                   search_done, search_done_d;
  logic                   overrun, overrun_d;
  logic                   search_en;
  logic [1:0]             load_loc;

  always_comb begin
    state_d       = state;
    next_loc_d    = next_loc;
    curr_loc_d    = curr_loc;
    prev_loc_d    = prev_loc;
    pending_d     = pending;
    seen_d        = seen;
    row_d         = row;
    sub_d         = sub;
    phase_d       = phase;
    cmd_valid_d   = cmd_valid;
    rd_addr_d     = rd_addr;
    rd_sel_d      = rd_sel;
    rd_curr_d     = rd_curr;
    search_done_d = 1'b0;
    overrun_d     = 1'b0;
    search_en     = 1'b0;
    nrow          = row;
    nphase        = phase;
    load_loc      = curr_loc;

    // Frames completing while busy are queued once; a second one is lost.
    if (state != S_IDLE && bus.i_frame_done) begin
      if (pending) overrun_d = 1'b1;
      else         pending_d = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (bus.i_frame_done || pending) begin
          state_d   = S_ROTATE;
          // Both at once: service the queued frame now, keep the new one queued.
          pending_d = bus.i_frame_done && pending;
        end
      end
      S_ROTATE: begin
        prev_loc_d = curr_loc;
        curr_loc_d = next_loc;
        next_loc_d = prev_loc;
        seen_d     = (seen == 2'd2) ? 2'd2 : seen + 2'd1;
`ifdef GCBP_SEARCH_WARMUP_EN
        search_en  = (seen_d == 2'd2);
`else
        search_en  = 1'b1;
`endif
        state_d    = search_en ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        // row/phase name the command on the bus while valid, else the one to load.
        if (!cmd_valid) begin
          cmd_valid_d = 1'b1;
        end else if (bus.i_cmd_ready) begin
          if (row == ROW_BITS'(C_SUBIMAGE_HEIGHT - 1) && phase) begin
            cmd_valid_d = 1'b0;
            row_d       = '0;
            phase_d     = 1'b0;
            state_d     = S_WAIT_MATCH;
          end else begin
            nrow    = phase ? row + ROW_BITS'(1) : row;
            nphase  = !phase;
            row_d   = nrow;
            phase_d = nphase;
          end
        end
        load_loc  = nphase ? prev_loc : curr_loc;
        rd_addr_d = (C_ADDR_BITS'(load_loc) << C_FRAME_BASE_SHIFT) + C_ADDR_BITS'(nrow);
        rd_sel_d  = sub;
        rd_curr_d = !nphase;
      end
      S_WAIT_MATCH: begin
        if (bus.i_match_done) begin
          if (sub == 4'(C_NUM_SUBIMAGES - 1)) begin
            state_d       = S_DONE;
            search_done_d = 1'b1;
          end else begin
            sub_d   = sub + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        sub_d   = '0;
        phase_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state       <= S_IDLE;
      next_loc    <= 2'd0;
      curr_loc    <= 2'd1;
      prev_loc    <= 2'd2;
      pending     <= 1'b0;
      seen        <= 2'd0;
      row         <= '0;
      sub         <= '0;
      phase       <= 1'b0;
      cmd_valid   <= 1'b0;
      rd_addr     <= '0;
      rd_sel      <= '0;
      rd_curr     <= 1'b0;
      busy        <= 1'b0;
      search_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      next_loc    <= next_loc_d;
      curr_loc    <= curr_loc_d;
      prev_loc    <= prev_loc_d;
      pending     <= pending_d;
      seen        <= seen_d;
      row         <= row_d;
      sub         <= sub_d;
      phase       <= phase_d;
      cmd_valid   <= cmd_valid_d;
      rd_addr     <= rd_addr_d;
      rd_sel      <= rd_sel_d;
      rd_curr     <= rd_curr_d;
      busy        <= busy_d;
      search_done <= search_done_d;
      overrun     <= overrun_d;
    end
  end

  assign bus.o_next_frame_loc = next_loc;
  assign bus.o_curr_frame_loc = curr_loc;
  assign bus.o_prev_frame_loc = prev_loc;
  assign bus.o_cmd_valid      = cmd_valid;
  assign bus.o_rd_addr        = rd_addr;
  assign bus.o_rd_sel         = rd_sel;
  assign bus.o_rd_curr        = rd_curr;
  assign bus.o_busy           = busy;
  assign bus.o_search_done    = search_done;
  assign bus.o_overrun        = overrun;
  assign bus.state_dbg        = state;

endmodule
